// File: rtl/metropolis_accept_unit.sv
`default_nettype none
// ============================================================================
// metropolis_accept_unit : Metropolis accept/reject decision stage with
//   internal Galois LFSR and saturating accept/reject statistics.
// Revision: 1.0
// ============================================================================
module metropolis_accept_unit #(
  parameter int CLAUSE_IDX_W = 3,
  parameter int RAND_W       = 8,
  parameter int CNT_W        = 16
) (
  input  logic                    in_clock,
  input  logic                    in_reset,
  input  logic [15:0]             in_seed,
  input  logic                    in_valid,
  output logic                    out_in_ready,
  input  logic [CLAUSE_IDX_W:0]   in_u,
  input  logic [CLAUSE_IDX_W:0]   in_v,
  input  logic [1:0]              in_temp,
  output logic                    out_valid,
  input  logic                    in_ready,
  output logic                    out_accept,
  input  logic                    in_clear_stats,
  output logic [CNT_W-1:0]        out_accept_count,
  output logic [CNT_W-1:0]        out_reject_count
);

  localparam int          c_dw        = CLAUSE_IDX_W + 2;
  localparam logic [15:0] c_poly      = 16'hB400;
  localparam logic [31:0] c_rand_w    = RAND_W;
  localparam logic [RAND_W:0] c_th_full = {1'b1, {RAND_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CLAUSE_IDX_W:0]   r_u;
  logic [CLAUSE_IDX_W:0]   r_v;
  logic [1:0]              r_temp;
  logic [15:0]             r_lfsr;
  logic                    r_valid;
  logic                    r_accept;
  logic [CNT_W-1:0]        r_acc_cnt;
  logic [CNT_W-1:0]        r_rej_cnt;

  logic [c_dw-1:0]         w_delta;
  logic [c_dw-1:0]         w_mag;
  logic [c_dw-1:0]         w_e;
  logic [RAND_W:0]         w_th;
  logic                    w_accept;
  logic [15:0]             w_lfsr_nxt;
  logic                    w_deliver;

  assign out_in_ready     = (r_state == S_IDLE) && !in_reset;
  assign out_valid        = r_valid;
  assign out_accept       = r_accept;
  assign out_accept_count = r_acc_cnt;
  assign out_reject_count = r_rej_cnt;
  assign w_deliver        = (r_state == S_HOLD) && in_ready;

  always_ff @(posedge in_clock) begin
    if (in_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (in_valid) w_state_nxt = S_COMPUTE;
      S_COMPUTE: w_state_nxt = S_HOLD;
      S_HOLD:    if (in_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // One extra bit on both operands keeps u - v from wrapping positive.
  always_comb begin
    w_delta    = {1'b0, r_u} - {1'b0, r_v};
    w_mag      = -w_delta;
    w_e        = w_mag >> r_temp;
    w_th       = (32'(w_e) >= c_rand_w) ? '0 : (c_th_full >> w_e);
    w_accept   = w_delta[c_dw-1] ? ({1'b0, r_lfsr[RAND_W-1:0]} < w_th) : 1'b1;
    w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_poly) : (r_lfsr >> 1);
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_lfsr    <= (in_seed == 16'h0000) ? 16'h0001 : in_seed;
      r_valid   <= 1'b0;
      r_accept  <= 1'b0;
      r_u       <= '0;
      r_v       <= '0;
      r_temp    <= '0;
      r_acc_cnt <= '0;
      r_rej_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && in_valid) begin
        r_u    <= in_u;
        r_v    <= in_v;
        r_temp <= in_temp;
      end
      if (r_state == S_COMPUTE) begin
        r_lfsr   <= w_lfsr_nxt;
        r_accept <= w_accept;
        r_valid  <= 1'b1;
      end
      if (w_deliver) r_valid <= 1'b0;
      // Clearing takes priority over the delivery increment.
      if (in_clear_stats) begin
        r_acc_cnt <= '0;
        r_rej_cnt <= '0;
      end else if (w_deliver) begin
        if (r_accept && r_acc_cnt != '1)  r_acc_cnt <= r_acc_cnt + CNT_W'(1);
        if (!r_accept && r_rej_cnt != '1) r_rej_cnt <= r_rej_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_metropolis_accept_unit.sv
`default_nettype none
// ============================================================================
// tb_metropolis_accept_unit : self-checking bench for metropolis_accept_unit
// Revision: 1.0
// ============================================================================
module tb_metropolis_accept_unit;

  localparam int CW = 3;
  localparam int RW = 8;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   seed;
  logic          in_valid;
  logic          in_rdy_o;
  logic [CW:0]   u_i;
  logic [CW:0]   v_i;
  logic [1:0]    temp_i;
  logic          out_valid;
  logic          in_ready;
  logic          out_accept;
  logic          clr;
  logic [NW-1:0] acc_cnt;
  logic [NW-1:0] rej_cnt;

  always #5 clk = ~clk;

  metropolis_accept_unit #(
    .CLAUSE_IDX_W(CW),
    .RAND_W      (RW),
    .CNT_W       (NW)
  ) dut (
    .in_clock        (clk),
    .in_reset        (rst),
    .in_seed         (seed),
    .in_valid        (in_valid),
    .out_in_ready    (in_rdy_o),
    .in_u            (u_i),
    .in_v            (v_i),
    .in_temp         (temp_i),
    .out_valid       (out_valid),
    .in_ready        (in_ready),
    .out_accept      (out_accept),
    .in_clear_stats  (clr),
    .out_accept_count(acc_cnt),
    .out_reject_count(rej_cnt)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_lfsr;
  int          m_acc;
  int          m_rej;

  typedef struct {
    int u;
    int v;
    int temp;
    bit exp;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: acceptance from the probability rule with plain integer arithmetic.
  function automatic bit model_accept(input int u, input int v, input int temp, input logic [15:0] l);
    int e;
    int th;
    int r;
    if (u >= v) return 1'b1;
    e  = (v - u) >> temp;
    th = (e >= RW) ? 0 : (1 << (RW - e));
    r  = int'(l) % (1 << RW);
    return r < th;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic [15:0] s;
    s = l >> 1;
    if (l[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_acc_cnt"}, 32'(acc_cnt), 32'(m_acc));
    check({tag, "_rej_cnt"}, 32'(rej_cnt), 32'(m_rej));
  endtask

  task automatic request(input int u, input int v, input int temp, input int hold,
                         input bit clr_hs, input bit clr_done, output bit dut_acc);
    bit exp;
    check("ready_idle", 32'(in_rdy_o), 32'd1);
    in_valid = 1'b1;
    u_i      = (CW+1)'(u);
    v_i      = (CW+1)'(v);
    temp_i   = 2'(temp);
    clr      = clr_hs;
    step();
    if (clr_hs) begin
      m_acc = 0;
      m_rej = 0;
    end
    in_valid = 1'b0;
    clr      = 1'b0;
    u_i      = (CW+1)'($urandom);
    v_i      = (CW+1)'($urandom);
    temp_i   = 2'($urandom);
    check("valid_lat1", 32'(out_valid), 32'd0);
    check("ready_busy", 32'(in_rdy_o), 32'd0);
    step();
    exp    = model_accept(u, v, temp, m_lfsr);
    m_lfsr = lfsr_next(m_lfsr);
    check("valid_lat2", 32'(out_valid), 32'd1);
    check("accept", 32'(out_accept), 32'(exp));
    dut_acc = out_accept;
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_accept", 32'(out_accept), 32'(exp));
      check("hold_ready", 32'(in_rdy_o), 32'd0);
      check_counts("hold");
    end
    in_ready = 1'b1;
    clr      = clr_done;
    step();
    in_ready = 1'b0;
    clr      = 1'b0;
    if (clr_done) begin
      m_acc = 0;
      m_rej = 0;
    end else if (exp) begin
      if (m_acc < CNT_MAX) m_acc++;
    end else begin
      if (m_rej < CNT_MAX) m_rej++;
    end
    check("done_valid", 32'(out_valid), 32'd0);
    check("done_ready", 32'(in_rdy_o), 32'd1);
    check_counts("done");
  endtask

  task automatic frac_run(input string name, input int u, input int v, input int temp,
                          input int n, input int lo_pm, input int hi_pm);
    int k;
    bit a;
    k = 0;
    for (int i = 0; i < n; i++) begin
      request(u, v, temp, 0, 1'b0, 1'b0, a);
      if (a) k++;
    end
    n_checks++;
    if (k * 1000 < lo_pm * n || k * 1000 > hi_pm * n) begin
      n_errors++;
      $display("FAIL %s: got %0d accepts of %0d, required %0d..%0d per mille", name, k, n, lo_pm, hi_pm);
    end
    check({name, "_lfsr"}, 32'(dut.r_lfsr), 32'(m_lfsr));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit a;
    tbl[0] = '{3, 3, 0, 1'b1};
    tbl[1] = '{5, 2, 0, 1'b1};
    tbl[2] = '{0, 8, 0, 1'b0};
    tbl[3] = '{0, 15, 0, 1'b0};
    tbl[4] = '{7, 15, 0, 1'b0};
    tbl[5] = '{15, 0, 3, 1'b1};
    tbl[6] = '{2, 10, 0, 1'b0};
    tbl[7] = '{0, 0, 2, 1'b1};

    rst = 1'b1; seed = 16'h0000; in_valid = 1'b0; u_i = '0; v_i = '0;
    temp_i = '0; in_ready = 1'b0; clr = 1'b0;
    step();
    step();
    check("rst_ready", 32'(in_rdy_o), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_accept", 32'(out_accept), 32'd0);
    check("rst_acc_cnt", 32'(acc_cnt), 32'd0);
    check("rst_rej_cnt", 32'(rej_cnt), 32'd0);
    check("rst_lfsr_zero_seed", 32'(dut.r_lfsr), 32'h0001);
    rst = 1'b0;
    m_lfsr = 16'h0001; m_acc = 0; m_rej = 0;
    step();

    for (int i = 0; i < 8; i++) begin
      request(tbl[i].u, tbl[i].v, tbl[i].temp, 0, 1'b0, 1'b0, a);
      check("tbl_accept", 32'(a), 32'(tbl[i].exp));
      if (i == 0) check("lfsr_first_advance", 32'(dut.r_lfsr), 32'h0000B400);
      check("tbl_lfsr", 32'(dut.r_lfsr), 32'(m_lfsr));
    end

    // Long hold with consumer stalled.
    request(2, 3, 0, 5, 1'b0, 1'b0, a);

    // Saturation of the 4-bit accept counter.
    request(1, 1, 0, 0, 1'b1, 1'b0, a);
    for (int i = 0; i < 19; i++) request(5, 2, 0, 0, 1'b0, 1'b0, a);
    check("sat_acc", 32'(acc_cnt), 32'd15);
    check("sat_rej", 32'(rej_cnt), 32'd0);

    // Clear together with a handshake, then clear against a delivery.
    request(0, 8, 0, 0, 1'b0, 1'b0, a);
    request(0, 8, 0, 0, 1'b1, 1'b0, a);
    check("clr_hs_acc", 32'(acc_cnt), 32'd0);
    check("clr_hs_rej", 32'(rej_cnt), 32'd1);
    request(4, 4, 0, 2, 1'b0, 1'b1, a);
    check("clr_done_acc", 32'(acc_cnt), 32'd0);
    check("clr_done_rej", 32'(rej_cnt), 32'd0);

    // Reset while a decision is held: discarded, LFSR reseeded.
    request(3, 1, 0, 0, 1'b0, 1'b0, a);
    in_valid = 1'b1; u_i = 4'd6; v_i = 4'd1; temp_i = 2'd0;
    step();
    in_valid = 1'b0;
    step();
    check("abort_valid_pre", 32'(out_valid), 32'd1);
    rst = 1'b1; seed = 16'hACE1; in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_accept", 32'(out_accept), 32'd0);
    check("abort_ready", 32'(in_rdy_o), 32'd0);
    check("abort_acc_cnt", 32'(acc_cnt), 32'd0);
    check("abort_rej_cnt", 32'(rej_cnt), 32'd0);
    check("abort_lfsr", 32'(dut.r_lfsr), 32'h0000ACE1);
    rst = 1'b0;
    m_lfsr = 16'hACE1; m_acc = 0; m_rej = 0;
    step();
    check("abort_ready_after", 32'(in_rdy_o), 32'd1);

    frac_run("frac_th128", 2, 3, 0, 4000, 480, 520);
    frac_run("frac_th32", 0, 3, 0, 8000, 115, 135);
    frac_run("frac_temp1", 0, 3, 1, 4000, 480, 520);

    for (int i = 0; i < 300; i++) begin
      request($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
              $urandom_range(0, 3), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), a);
    end
    check("rand_lfsr", 32'(dut.r_lfsr), 32'(m_lfsr));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
